fifo_rd_stream: RTL and testbench

//  Read-side controller for the image async FIFO: drains words from the FIFO read port (rd_en/rd_data/empty, 1-cycle read latency)
//  and presents them as a valid/ready pixel stream with frame framing (sof, end-of-line).

---
 rtl/fifo_rd_stream_if.sv | 24 ++
 rtl/fifo_rd_stream.sv | 131 +++++++++++++
 tb/tb_fifo_rd_stream.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_stream_if.sv
// Bundles the FIFO read port and the outgoing pixel stream of fifo_rd_stream.
// master = the read controller, slave = the FIFO/downstream environment around it.
interface fifo_rd_stream_if #(
    parameter int DSIZE = 8
);
    logic             fifo_empty;
    logic [DSIZE-1:0] fifo_rd_data;
    logic             fifo_rd_en;
    logic             m_valid;
    logic             m_ready;
    logic [DSIZE-1:0] m_data;
    logic             m_sof;
    logic             m_eol;

    modport master (
        input  fifo_empty, fifo_rd_data, m_ready,
        output fifo_rd_en, m_valid, m_data, m_sof, m_eol
    );

    modport slave (
        output fifo_empty, fifo_rd_data, m_ready,
        input  fifo_rd_en, m_valid, m_data, m_sof, m_eol
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// Drains the image FIFO read port into a framed valid/ready pixel stream via a 2-entry buffer.
// Optional mid-frame starvation counter enabled by defining UNDERRUN_CNT_EN.
module fifo_rd_stream #(
    parameter int DSIZE      = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic             rd_clk,
    input  logic             rd_rst,
    fifo_rd_stream_if.master bus,
    output logic             frame_done,
    output logic [15:0]      underrun_cnt
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [DSIZE-1:0] buf0_q, buf0_d;
    logic [DSIZE-1:0] buf1_q, buf1_d;
    logic [1:0]       count_q, count_d;
    logic             inflight_q, inflight_d;
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic             frame_done_q, frame_done_d;

    logic       valid;
    logic       pop;
    logic       rd_en;
    logic       col_last;
    logic       row_last;
    logic [1:0] occupancy;

    always_comb begin
        valid     = (count_q != 2'd0);
        pop       = valid & bus.m_ready;
        col_last  = (col_q == COL_LAST);
        row_last  = (row_q == ROW_LAST);
        // Buffered words plus the word in flight never exceed 2, so this cannot wrap.
        occupancy = count_q + {1'b0, inflight_q} - {1'b0, pop};
        rd_en     = ~bus.fifo_empty & ~rd_rst & (occupancy < 2'd2);
    end

    always_comb begin
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        count_d = count_q;
        case ({inflight_q, pop})
            2'b01: begin
                buf0_d  = buf1_q;
                count_d = count_q - 2'd1;
            end
            2'b10: begin
                if (count_q == 2'd0) buf0_d = bus.fifo_rd_data;
                else                 buf1_d = bus.fifo_rd_data;
                count_d = count_q + 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    buf0_d = bus.fifo_rd_data;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = bus.fifo_rd_data;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        inflight_d   = rd_en;
        frame_done_d = pop & col_last & row_last;
        if (pop) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            buf0_q       <= '0;
            buf1_q       <= '0;
            count_q      <= 2'd0;
            inflight_q   <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            buf0_q       <= buf0_d;
            buf1_q       <= buf1_d;
            count_q      <= count_d;
            inflight_q   <= inflight_d;
            col_q        <= col_d;
            row_q        <= row_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = valid;
    assign bus.m_data     = buf0_q;
    assign bus.m_sof      = valid & (col_q == '0) & (row_q == '0);
    assign bus.m_eol      = valid & col_last;
    assign frame_done     = frame_done_q;

`ifdef UNDERRUN_CNT_EN
    logic [15:0] underrun_q, underrun_d;

    // Counts only starvation inside a frame; idling between frames is expected.
    always_comb begin
        underrun_d = underrun_q;
        if (bus.m_ready & ~valid & ((col_q != '0) | (row_q != '0)) & (underrun_q != 16'hFFFF))
            underrun_d = underrun_q + 16'd1;
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) underrun_q <= 16'h0000;
        else        underrun_q <= underrun_d;
    end

    assign underrun_cnt = underrun_q;
`else
    assign underrun_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream with a 4x2 frame and a behavioural 1-cycle-latency FIFO.
// Expected underrun count depends on whether UNDERRUN_CNT_EN is defined for the build.
module tb_fifo_rd_stream;
    localparam int DSIZE      = 8;
    localparam int IMG_WIDTH  = 4;
    localparam int IMG_HEIGHT = 2;
    localparam int FRAME      = IMG_WIDTH * IMG_HEIGHT;

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
        logic       eol;
        logic       last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rd_rst = 1'b1;
    logic        frame_done;
    logic [15:0] underrun_cnt;
    logic        gap = 1'b0;

    logic [7:0] fifo_q[$];
    exp_t       exp_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int pop_count   = 0;
    int rd_issued   = 0;
    int cyc         = 0;
    int pos         = 0;
    int pop_cycle[8];

    fifo_rd_stream_if #(.DSIZE(DSIZE)) bus ();

    fifo_rd_stream #(
        .DSIZE(DSIZE),
        .IMG_WIDTH(IMG_WIDTH),
        .IMG_HEIGHT(IMG_HEIGHT)
    ) dut (
        .rd_clk(clk),
        .rd_rst(rd_rst),
        .bus(bus),
        .frame_done(frame_done),
        .underrun_cnt(underrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        vectors++;
        if (actual !== required) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, required, $time);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic sof, input logic eol, input logic last);
        exp_t e;
        e.data = data;
        e.sof  = sof;
        e.eol  = eol;
        e.last = last;
        fifo_q.push_back(data);
        exp_q.push_back(e);
    endtask

    task automatic pushPixel(input logic [7:0] data);
        applyStimulus(data, pos == 0, (pos % IMG_WIDTH) == IMG_WIDTH - 1, pos == FRAME - 1);
        pos = (pos + 1) % FRAME;
    endtask

    task automatic waitDrain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL %s: %0d words still pending after %0d cycles, expected 0", name, exp_q.size(), budget);
        end
    endtask

    // Behavioural FIFO: read accepted on a cycle returns its word one cycle later.
    initial begin : fifo_model
        logic       issue;
        logic [7:0] word;
        issue = 1'b0;
        word  = 8'h00;
        bus.fifo_empty   = 1'b1;
        bus.fifo_rd_data = 8'h00;
        forever begin
            @(posedge clk);
            if (issue) word = (fifo_q.size() != 0) ? fifo_q.pop_front() : 8'h00;
            #1;
            bus.fifo_rd_data = word;
            bus.fifo_empty   = (fifo_q.size() == 0) | gap;
            @(negedge clk);
            issue = bus.fifo_rd_en;
            if (issue) begin
                checkOutput("rd_while_empty", {31'd0, bus.fifo_empty}, 32'd0);
                rd_issued++;
            end
        end
    end

    initial begin : monitor
        exp_t       e;
        logic       fd_exp;
        logic       hold;
        logic [7:0] hold_data;
        fd_exp    = 1'b0;
        hold      = 1'b0;
        hold_data = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            if (frame_done || fd_exp)
                checkOutput("frame_done", {31'd0, frame_done}, {31'd0, fd_exp});
            if (hold)
                checkOutput("hold_stable", {23'd0, bus.m_valid, bus.m_data}, {23'd0, 1'b1, hold_data});
            if (!bus.m_valid)
                checkOutput("idle_flags", {30'd0, bus.m_sof, bus.m_eol}, 32'd0);
            fd_exp = 1'b0;
            if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_pop: got data 0x%0h, expected no word", bus.m_data);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("pop_word", {22'd0, bus.m_data, bus.m_sof, bus.m_eol},
                                {22'd0, e.data, e.sof, e.eol});
                    fd_exp = e.last;
                    if (pop_count < 8) pop_cycle[pop_count] = cyc;
                    pop_count++;
                end
            end
            hold      = bus.m_valid && !bus.m_ready && !rd_rst;
            hold_data = bus.m_data;
            if (rd_rst) fd_exp = 1'b0;
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [7:0] sof_tab;
        logic [7:0] eol_tab;
        int         rd_start;
        int         start;
        int         n;
        logic [15:0] underrun_exp;
        sof_tab = 8'b0000_0001;
        eol_tab = 8'b1000_1000;
        bus.m_ready = 1'b0;
        rd_rst = 1'b1;

        // Frame of 0x10..0x17 sits in the FIFO while reset holds everything quiet.
        for (int i = 0; i < 8; i++)
            applyStimulus(8'(16 + i), sof_tab[i], eol_tab[i], i == 7);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("reset_rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
            checkOutput("reset_outputs", {4'd0, bus.m_valid, bus.m_data, bus.m_sof, bus.m_eol,
                                          frame_done, underrun_cnt}, 32'd0);
        end
        @(posedge clk);
        #1 rd_rst = 1'b0;
        $display("[TB] streaming one frame");
        waitDrain("stream_drain", 40);
        checkOutput("stream_back_to_back", 32'(pop_cycle[7] - pop_cycle[0]), 32'd7);

        $display("[TB] backpressure");
        @(posedge clk);
        #1 bus.m_ready = 1'b0;
        rd_start = rd_issued;
        for (int i = 0; i < 6; i++) pushPixel(8'(32 + i));
        repeat (10) @(posedge clk);
        #2;
        checkOutput("bp_reads", 32'(rd_issued - rd_start), 32'd2);
        checkOutput("bp_head", {23'd0, bus.m_valid, bus.m_data}, {23'd0, 1'b1, 8'h20});
        bus.m_ready = 1'b1;
        waitDrain("bp_drain", 40);

        $display("[TB] random ready and FIFO gaps");
        for (int i = 0; i < 26; i++) pushPixel(8'(48 + i));
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            #1;
            bus.m_ready = 1'($urandom_range(0, 1));
            gap         = ($urandom_range(0, 3) == 0);
            n++;
        end
        gap = 1'b0;
        bus.m_ready = 1'b1;
        waitDrain("random_drain", 50);

        $display("[TB] reset mid-line");
        @(posedge clk);
        #1 bus.m_ready = 1'b0;
        for (int i = 0; i < 4; i++) pushPixel(8'(96 + i));
        repeat (6) @(posedge clk);
        #1 bus.m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.m_ready = 1'b0;
        rd_rst = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        pos = 0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midreset_rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
        checkOutput("midreset_outputs", {4'd0, bus.m_valid, bus.m_data, bus.m_sof, bus.m_eol,
                                         frame_done, underrun_cnt}, 32'd0);
        @(posedge clk);
        #1;
        rd_rst = 1'b0;
        bus.m_ready = 1'b1;
        pushPixel(8'h70);

        // Starve the stream right after the first pixel of a new frame.
        start = pop_count;
        n = 0;
        while (pop_count == start && n < 20) begin
            @(posedge clk);
            n++;
        end
        vectors++;
        if (pop_count == start) begin
            miscompares++;
            $display("[TB] FAIL post_reset_pop: no pop within 20 cycles, expected 1 pop");
        end
        repeat (5) @(posedge clk);
        #1;
`ifdef UNDERRUN_CNT_EN
        underrun_exp = 16'd5;
`else
        underrun_exp = 16'd0;
`endif
        checkOutput("underrun_cnt", {16'd0, underrun_cnt}, {16'd0, underrun_exp});
        checkOutput("final_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
